// File: rtl/math_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : math_pkg
//  Purpose  : Shared types and widths for the math issue queue and the EX10
//             operand-read stage that consumes its issue packet.
//  Contents : ROB_W / PRF_W widths, queue entry struct, 18-bit issue packet
//             layout {rs2[17:12], rs1[11:6], reserved[5], rob[4:0]} and a
//             helper that builds a packet from entry fields.
//  Revision : 1.0 - initial release
// ============================================================================
package math_pkg;

    localparam int ROB_W   = 5;
    localparam int PRF_W   = 6;
    localparam int ISSUE_W = 2 * PRF_W + 1 + ROB_W;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob;
        logic [PRF_W-1:0] rs1;
        logic             rs1_rdy;
        logic [PRF_W-1:0] rs2;
        logic             rs2_rdy;
        logic             imm;
    } mathiq_entry_t;

    // Field order is MSB first, so rob lands in bits [4:0].
    typedef struct packed {
        logic [PRF_W-1:0] rs2;
        logic [PRF_W-1:0] rs1;
        logic             rsvd;
        logic [ROB_W-1:0] rob;
    } mathiq_issue_pkt_t;

    function automatic mathiq_issue_pkt_t mathiq_make_pkt(
        input logic [ROB_W-1:0] rob,
        input logic [PRF_W-1:0] rs1,
        input logic [PRF_W-1:0] rs2
    );
        mathiq_issue_pkt_t pkt;
        pkt.rs2  = rs2;
        pkt.rs1  = rs1;
        pkt.rsvd = 1'b0;
        pkt.rob  = rob;
        return pkt;
    endfunction

endpackage : math_pkg
`default_nettype wire

// File: rtl/mathiq_select.sv
`default_nettype none
// ============================================================================
//  Module   : mathiq_select
//  Purpose  : Find-first-one over DEPTH request bits; lowest index wins.
//  Ports    : req_i   [DEPTH]          request (ready) vector
//             grant_o [DEPTH]          one-hot grant of lowest set request
//             idx_o   [$clog2(DEPTH)]  encoded index of the grant
//             any_o                    at least one request is set
//  Revision : 1.0 - initial release
// ============================================================================
module mathiq_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic w_found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && !w_found) begin
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule : mathiq_select
`default_nettype wire

// File: rtl/math_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : math_issue_queue
//  Purpose  : Collapsing, age-ordered issue queue for the math (ALU) pipe.
//             Entry 0 is always the oldest. Sources become ready through
//             result-tag wakeup broadcasts; each cycle the oldest ready entry
//             is registered out as an 18-bit packet and removed.
//  Ports    : cpu_clock_i / cpu_resetn_i   clock, async active-low reset
//             flush_i                      empties the queue
//             enq_*_i                      dispatch write port
//             full_o / count_o             occupancy status
//             wake_valid_i / wake_tag_i    WAKE_PORTS tag broadcasts
//             issue_data_o / issue_valid_o registered issue packet to EX10
//  Options  : MATHIQ_WAKEUP_BYPASS_EN - selection also sees same-cycle
//             wakeup matches (wakeup-to-issue in one cycle instead of two).
//  Revision : 1.0 - initial release
// ============================================================================
module math_issue_queue
    import math_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WAKE_PORTS = 2
) (
    input  logic                        cpu_clock_i,
    input  logic                        cpu_resetn_i,
    input  logic                        flush_i,
    input  logic                        enq_valid_i,
    input  logic [ROB_W-1:0]            enq_rob_i,
    input  logic [PRF_W-1:0]            enq_rs1_i,
    input  logic [PRF_W-1:0]            enq_rs2_i,
    input  logic                        enq_rs1_rdy_i,
    input  logic                        enq_rs2_rdy_i,
    input  logic                        enq_imm_i,
    output logic                        full_o,
    output logic [$clog2(DEPTH):0]      count_o,
    input  logic [WAKE_PORTS-1:0]       wake_valid_i,
    input  logic [WAKE_PORTS*PRF_W-1:0] wake_tag_i,
    output logic [ISSUE_W-1:0]          issue_data_o,
    output logic                        issue_valid_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    mathiq_entry_t     entries_q [DEPTH];
    mathiq_entry_t     entries_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              issue_valid_q, issue_valid_d;
    mathiq_issue_pkt_t issue_data_q, issue_data_d;

    // Stored entries after this cycle's wakeup; one extra empty slot at the
    // top so the collapse shift can read index i+1 uniformly.
    mathiq_entry_t     w_woken [DEPTH+1];
    mathiq_entry_t     w_new;
    mathiq_issue_pkt_t w_sel_pkt;
    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_grant;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_any_ready;
    logic              w_full;
    logic              w_issue;
    logic              w_enq_acc;
    logic [CNT_W-1:0]  w_enq_pos;

    function automatic logic f_wake_hit(
        input logic [PRF_W-1:0]            tag,
        input logic [WAKE_PORTS-1:0]       vld,
        input logic [WAKE_PORTS*PRF_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            if (vld[p] && (tags[p*PRF_W +: PRF_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign w_full = (count_q == CNT_W'(DEPTH));

    // ------------------------------------------------------------------
    // Ready vector feeding selection. The imm flag stands in for rs2.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef MATHIQ_WAKEUP_BYPASS_EN
            w_ready[i] = entries_q[i].valid
                & (entries_q[i].rs1_rdy
                   | f_wake_hit(entries_q[i].rs1, wake_valid_i, wake_tag_i))
                & (entries_q[i].rs2_rdy | entries_q[i].imm
                   | f_wake_hit(entries_q[i].rs2, wake_valid_i, wake_tag_i));
`else
            w_ready[i] = entries_q[i].valid & entries_q[i].rs1_rdy
                & (entries_q[i].rs2_rdy | entries_q[i].imm);
`endif
        end
    end

    mathiq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .req_i   (w_ready),
        .grant_o (w_grant),
        .idx_o   (w_sel_idx),
        .any_o   (w_any_ready)
    );

    always_comb begin
        w_sel_pkt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_pkt = mathiq_make_pkt(entries_q[i].rob, entries_q[i].rs1,
                                            entries_q[i].rs2);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state: wakeup, collapse shift, enqueue, flush.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = entries_q[i];
            if (f_wake_hit(entries_q[i].rs1, wake_valid_i, wake_tag_i)) begin
                w_woken[i].rs1_rdy = 1'b1;
            end
            if (f_wake_hit(entries_q[i].rs2, wake_valid_i, wake_tag_i)) begin
                w_woken[i].rs2_rdy = 1'b1;
            end
        end
        w_woken[DEPTH] = '0;

        w_issue   = w_any_ready & ~flush_i;
        w_enq_acc = enq_valid_i & ~w_full & ~flush_i;
        // The issued entry frees a slot below the top, so the newcomer
        // lands one lower when an issue happens in the same edge.
        w_enq_pos = w_issue ? (count_q - CNT_W'(1)) : count_q;

        // Tag 0 and same-cycle wakeups make the incoming source ready.
        w_new.valid   = 1'b1;
        w_new.rob     = enq_rob_i;
        w_new.rs1     = enq_rs1_i;
        w_new.rs1_rdy = enq_rs1_rdy_i | (enq_rs1_i == '0)
                        | f_wake_hit(enq_rs1_i, wake_valid_i, wake_tag_i);
        w_new.rs2     = enq_rs2_i;
        w_new.rs2_rdy = enq_rs2_rdy_i | (enq_rs2_i == '0)
                        | f_wake_hit(enq_rs2_i, wake_valid_i, wake_tag_i);
        w_new.imm     = enq_imm_i;

        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (IDX_W'(i) >= w_sel_idx)) begin
                entries_d[i] = w_woken[i+1];
            end else begin
                entries_d[i] = w_woken[i];
            end
            if (w_enq_acc && (CNT_W'(i) == w_enq_pos)) begin
                entries_d[i] = w_new;
            end
        end

        count_d       = count_q + CNT_W'(w_enq_acc) - CNT_W'(w_issue);
        issue_valid_d = w_issue;
        issue_data_d  = w_issue ? w_sel_pkt : issue_data_q;

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
        end
    end

    assign full_o        = w_full;
    assign count_o       = count_q;
    assign issue_valid_o = issue_valid_q;
    assign issue_data_o  = issue_data_q;

endmodule : math_issue_queue
`default_nettype wire

// File: tb/tb_math_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_math_issue_queue
//  Purpose  : Directed, scoreboard-checked bench for math_issue_queue.
//             Each expected issue carries its packet and the cycle in which
//             issue_valid_o must show it; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_math_issue_queue;

`ifdef MATHIQ_WAKEUP_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        cpu_resetn_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        enq_valid_i = 1'b0;
    logic [4:0]  enq_rob_i = '0;
    logic [5:0]  enq_rs1_i = '0;
    logic [5:0]  enq_rs2_i = '0;
    logic        enq_rs1_rdy_i = 1'b0;
    logic        enq_rs2_rdy_i = 1'b0;
    logic        enq_imm_i = 1'b0;
    logic        full_o;
    logic [3:0]  count_o;
    logic [1:0]  wake_valid_i = '0;
    logic [11:0] wake_tag_i = '0;
    logic [17:0] issue_data_o;
    logic        issue_valid_o;

    math_issue_queue #(
        .DEPTH      (8),
        .WAKE_PORTS (2)
    ) dut (
        .cpu_clock_i   (clk),
        .cpu_resetn_i  (cpu_resetn_i),
        .flush_i       (flush_i),
        .enq_valid_i   (enq_valid_i),
        .enq_rob_i     (enq_rob_i),
        .enq_rs1_i     (enq_rs1_i),
        .enq_rs2_i     (enq_rs2_i),
        .enq_rs1_rdy_i (enq_rs1_rdy_i),
        .enq_rs2_rdy_i (enq_rs2_rdy_i),
        .enq_imm_i     (enq_imm_i),
        .full_o        (full_o),
        .count_o       (count_o),
        .wake_valid_i  (wake_valid_i),
        .wake_tag_i    (wake_tag_i),
        .issue_data_o  (issue_data_o),
        .issue_valid_o (issue_valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] pkt;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (cpu_resetn_i && issue_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue cycle=%0d actual=%h required=none",
                         cyc, issue_data_o);
            end else begin
                mon_e = sb.pop_front();
                if (issue_data_o !== mon_e.pkt || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL issue actual=%h@cycle%0d required=%h@cycle%0d",
                             issue_data_o, cyc, mon_e.pkt, mon_e.at);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expect_issue(input logic [4:0] rob, input logic [5:0] rs1,
                                input logic [5:0] rs2, input int at);
        exp_t e;
        e.pkt = {rs2, rs1, 1'b0, rob};
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic drive_enq(input logic [4:0] rob, input logic [5:0] rs1,
                             input logic r1, input logic [5:0] rs2,
                             input logic r2, input logic imm);
        enq_valid_i   = 1'b1;
        enq_rob_i     = rob;
        enq_rs1_i     = rs1;
        enq_rs1_rdy_i = r1;
        enq_rs2_i     = rs2;
        enq_rs2_rdy_i = r2;
        enq_imm_i     = imm;
        step();
        enq_valid_i   = 1'b0;
        enq_imm_i     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int w;

        step();
        step();
        chk("reset_count", int'(count_o), 0);
        chk("reset_full", int'(full_o), 0);
        chk("reset_valid", int'(issue_valid_o), 0);
        chk("reset_data", int'(issue_data_o), 0);
        cpu_resetn_i = 1'b1;
        step();

        // Basic enqueue -> issue two cycles later.
        c = cyc;
        expect_issue(5'd3, 6'd5, 6'd7, c + 2);
        drive_enq(5'd3, 6'd5, 1'b1, 6'd7, 1'b1, 1'b0);
        chk("t1_count_after_enq", int'(count_o), 1);
        step();
        chk("t1_count_after_issue", int'(count_o), 0);
        step();

        // Younger ready entry overtakes a blocked older one; invalid wake
        // port carrying the right tag must not wake it.
        c = cyc;
        drive_enq(5'd1, 6'd9, 1'b0, 6'd10, 1'b1, 1'b0);
        expect_issue(5'd2, 6'd11, 6'd13, c + 3);
        drive_enq(5'd2, 6'd11, 1'b1, 6'd13, 1'b1, 1'b0);
        step();
        chk("t2_count_one_left", int'(count_o), 1);
        wake_valid_i = 2'b00;
        wake_tag_i   = {6'd0, 6'd9};
        step();
        wake_valid_i = 2'b10;
        wake_tag_i   = {6'd9, 6'd0};
        expect_issue(5'd1, 6'd9, 6'd10, cyc + LAT);
        step();
        wake_valid_i = 2'b00;
        wake_tag_i   = '0;
        step();
        step();

        // Immediate form: rs2 not ready but ignored.
        c = cyc;
        expect_issue(5'd4, 6'd14, 6'd12, c + 2);
        drive_enq(5'd4, 6'd14, 1'b1, 6'd12, 1'b0, 1'b1);
        step();
        step();
        step();

        // Fill to full with blocked entries, overflow enqueue, then drain.
        for (int i = 0; i < 8; i++) begin
            drive_enq(5'(i), 6'(16 + i), 1'b0, 6'(24 + i), 1'b1, 1'b0);
        end
        chk("t4_full", int'(full_o), 1);
        chk("t4_count_full", int'(count_o), 8);
        drive_enq(5'd9, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
        chk("t4_count_after_overflow", int'(count_o), 8);
        chk("t4_full_after_overflow", int'(full_o), 1);
        w = cyc;
        for (int i = 0; i < 8; i++) begin
            expect_issue(5'(i), 6'(16 + i), 6'(24 + i), w + LAT + i);
        end
        for (int k = 0; k < 4; k++) begin
            wake_valid_i = 2'b11;
            wake_tag_i   = {6'(17 + 2 * k), 6'(16 + 2 * k)};
            step();
        end
        wake_valid_i = 2'b00;
        wake_tag_i   = '0;
        for (int k = 0; k < 6; k++) step();
        chk("t4_drained_count", int'(count_o), 0);
        chk("t4_drained_full", int'(full_o), 0);

        // Enqueue and issue in the same edge at count 3.
        c = cyc;
        drive_enq(5'd10, 6'd30, 1'b0, 6'd33, 1'b1, 1'b0);
        drive_enq(5'd11, 6'd31, 1'b0, 6'd33, 1'b1, 1'b0);
        expect_issue(5'd12, 6'd34, 6'd35, c + 4);
        drive_enq(5'd12, 6'd34, 1'b1, 6'd35, 1'b1, 1'b0);
        chk("t5_count_before", int'(count_o), 3);
        drive_enq(5'd13, 6'd32, 1'b0, 6'd33, 1'b1, 1'b0);
        chk("t5_count_enq_and_issue", int'(count_o), 3);
        w = cyc;
        expect_issue(5'd11, 6'd31, 6'd33, w + LAT);
        expect_issue(5'd13, 6'd32, 6'd33, w + LAT + 1);
        wake_valid_i = 2'b11;
        wake_tag_i   = {6'd32, 6'd31};
        step();
        wake_valid_i = 2'b00;
        wake_tag_i   = '0;
        step();
        expect_issue(5'd10, 6'd30, 6'd33, w + 2 + LAT);
        wake_valid_i = 2'b01;
        wake_tag_i   = {6'd0, 6'd30};
        step();
        wake_valid_i = 2'b00;
        wake_tag_i   = '0;
        for (int k = 0; k < 4; k++) step();
        chk("t5_drained_count", int'(count_o), 0);

        // Flush with five queued, one selected, and an enqueue pending.
        for (int i = 0; i < 4; i++) begin
            drive_enq(5'(20 + i), 6'(40 + i), 1'b0, 6'd33, 1'b1, 1'b0);
        end
        drive_enq(5'd24, 6'd44, 1'b1, 6'd45, 1'b1, 1'b0);
        chk("t6_count_before_flush", int'(count_o), 5);
        flush_i = 1'b1;
        drive_enq(5'd25, 6'd46, 1'b1, 6'd47, 1'b1, 1'b0);
        flush_i = 1'b0;
        chk("t6_count_after_flush", int'(count_o), 0);
        chk("t6_valid_after_flush", int'(issue_valid_o), 0);
        chk("t6_full_after_flush", int'(full_o), 0);
        wake_valid_i = 2'b11;
        wake_tag_i   = {6'd41, 6'd40};
        step();
        wake_tag_i   = {6'd43, 6'd42};
        step();
        wake_valid_i = 2'b00;
        wake_tag_i   = '0;
        for (int k = 0; k < 4; k++) step();

        // Asynchronous reset in the middle of a cycle.
        drive_enq(5'd26, 6'd46, 1'b0, 6'd47, 1'b1, 1'b0);
        chk("t7_count_before_reset", int'(count_o), 1);
        #2;
        cpu_resetn_i = 1'b0;
        #1;
        chk("t7_async_reset_count", int'(count_o), 0);
        step();
        cpu_resetn_i = 1'b1;
        wake_valid_i = 2'b01;
        wake_tag_i   = {6'd0, 6'd46};
        step();
        wake_valid_i = 2'b00;
        wake_tag_i   = '0;
        for (int k = 0; k < 4; k++) step();
        chk("t7_count_after_reset", int'(count_o), 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_math_issue_queue
`default_nettype wire

// File: doc/math_issue_queue.md
Name: math_issue_queue

Overview:
- Collapsing, age-ordered issue queue for the math (ALU) pipe.
- Sits between dispatch/rename and the EX10 operand-read stage.
- Holds up to DEPTH micro-ops and tracks source readiness from result-tag wakeup broadcasts.
- Each cycle it issues the oldest ready entry as an 18-bit packet plus valid, which EX10 consumes via its data and valid inputs.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16)
- WAKE_PORTS, 2, number of result-tag wakeup broadcast ports

Ports:
- cpu_clock_i  in  1  clock
- cpu_resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; empties the queue
- enq_valid_i  in  1  dispatch write strobe
- enq_rob_i  in  5  ROB id
- enq_rs1_i  in  6  source 1 physical tag
- enq_rs2_i  in  6  source 2 physical tag
- enq_rs1_rdy_i  in  1  source 1 already available
- enq_rs2_rdy_i  in  1  source 2 already available
- enq_imm_i  in  1  uses immediate; rs2 treated as ready
- full_o  out  1  queue holds DEPTH entries
- count_o  out  $clog2(DEPTH)+1  occupancy
- wake_valid_i  in  WAKE_PORTS  per-port wakeup strobe
- wake_tag_i  in  WAKE_PORTS*6  per-port destination tag
- issue_data_o  out  18  [4:0] rob, [5] reserved (0), [11:6] rs1, [17:12] rs2
- issue_valid_o  out  1  issue_data_o valid this cycle

Behaviour:
- Reset (async, cpu_resetn_i low): all entry valid bits = 0, count_o = 0, full_o = 0, issue_valid_o = 0, issue_data_o = 0.
- Storage: entry 0 is always the oldest.
  - On issue of entry k, entries k+1..top shift down by one in the same edge.
  - An enqueue in the same cycle lands at index count−1 when an issue occurs, else at index count.
- Readiness:
  - An entry is ready when rdy1 & rdy2.
  - rdy2 is forced to 1 when the imm flag is set.
  - Tag 0 is always ready (hardwired zero register).
- Wakeup: at each edge, every stored source whose tag equals any valid wake_tag_i sets its rdy bit.
  - Enqueue bypass: an entry enqueued in the same cycle as a matching wakeup is stored already ready.
- Selection:
  - Combinational find-first over stored ready bits, lowest index wins.
  - At most one issue per cycle; no backpressure from downstream.
- Issue register:
  - The selected entry's packet is registered into issue_data_o and issue_valid_o = 1; the entry is removed at the same edge.
  - issue_valid_o = 0 when nothing is ready.
  - issue_data_o holds its last value when invalid.
- Latency (base build):
  - Enqueue-ready in cycle c → issue_valid_o high in cycle c+2.
  - Wakeup in cycle c → issue in c+2.
- full_o = (count == DEPTH), derived from the count register.
  - Enqueue while full_o = 1 is a protocol violation; the enqueue is ignored and count is unchanged.
- count_o next = count + enq_accepted − issued.
  - Simultaneous enqueue and issue leaves count unchanged.
- flush_i = 1:
  - At the edge, all valid bits clear, count = 0, issue_valid_o = 0.
  - Enqueue and issue in that cycle are discarded.
  - flush dominates everything except reset.
- Reset mid-operation: immediate clear regardless of clock; no partial shifts survive.

Optional Feature:
- MATHIQ_WAKEUP_BYPASS_EN
- With it defined: the selection ready term also ORs in the current-cycle wakeup match for each stored source, so wakeup in cycle c → issue_valid_o in c+1. Enqueue-to-issue latency is unchanged.
- Without it: selection uses stored ready bits only, giving the c+2 wakeup latency above.

Decomposition:
- math_pkg holds:
  - localparams ROB_W = 5 and PRF_W = 6
  - typedef struct mathiq_entry_t {valid, rob, rs1, rs1_rdy, rs2, rs2_rdy, imm}
  - the issue packet layout, shared with EX10
- One sub-module, mathiq_select: parameterised find-first-one over DEPTH ready bits, outputting the one-hot grant, the encoded index and any_ready.

Test Plan:
- Reset, then enqueue rob=3, rs1=5 rdy, rs2=7 rdy in cycle 1 → issue_valid_o = 1 in cycle 3 with issue_data_o = {7, 5, 0, 3}; count_o returns to 0.
- Enqueue rob=1 (rs1=9 not ready), then rob=2 (all ready) → rob=2 issues first. Drive wake tag 9 → rob=1 issues two cycles later (one with MATHIQ_WAKEUP_BYPASS_EN).
- Enqueue rob=4 with enq_imm_i = 1, rs2 = 12 not ready, rs1 ready → issues without any wakeup on tag 12.
- Fill 8 entries, none ready → full_o = 1. Extra enqueue is ignored and count_o stays 8. Wake all tags → entries drain in enqueue order rob 0..7, one per cycle.
- Enqueue and issue in the same cycle at count = 3 → count_o stays 3; the new entry sits at index 2 and its age order is preserved.
- With 5 entries queued and issue in flight, assert flush_i together with enq_valid_i → next cycle count_o = 0, issue_valid_o = 0, and no later issue of the flushed rob ids.
